// File: rtl/result_unload_unit_pkg.sv
// rtl/result_unload_unit_pkg.sv - shared constants and types for the result unload path
package result_unload_unit_pkg;

  localparam int COLS         = 8;
  localparam int PSUM_W       = 16;
  localparam int ADDR_W       = 6;
  localparam int RESULT_DEPTH = 64;
  localparam int COL_W        = $clog2(COLS);
  localparam int PASS_W       = ADDR_W - COL_W;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unload_state_e;

  typedef logic signed [PSUM_W-1:0] psum_t;

endpackage

// File: rtl/result_capture_buffer.sv
// rtl/result_capture_buffer.sv - COLS-entry capture register file with column read mux
// Optional ReLU clamp at capture when RESULT_UNLOAD_RELU_EN is defined.
module result_capture_buffer
  import result_unload_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [COLS*PSUM_W-1:0] psum_in_i,
  input  logic [COL_W-1:0]       rd_col_i,
  output logic [PSUM_W-1:0]      rd_data_o
);

  psum_t buf_q [COLS];
  psum_t buf_d [COLS];

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      buf_d[c] = psum_t'(psum_in_i[c*PSUM_W +: PSUM_W]);
`ifdef RESULT_UNLOAD_RELU_EN
      if (buf_d[c][PSUM_W-1]) begin
        buf_d[c] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) begin
        buf_q[c] <= '0;
      end
    end else if (load_i) begin
      for (int c = 0; c < COLS; c++) begin
        buf_q[c] <= buf_d[c];
      end
    end
  end

  assign rd_data_o = buf_q[rd_col_i];

endmodule

// File: rtl/result_unload_unit.sv
// rtl/result_unload_unit.sv - captures final column sums and streams them as (addr, data) words
// Build option: RESULT_UNLOAD_RELU_EN clamps negative sums to zero at capture.
module result_unload_unit
  import result_unload_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [COLS*PSUM_W-1:0] psum_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PSUM_W-1:0]      res_data,
  output logic [ADDR_W-1:0]      res_addr,
  output logic                   unload_done
);

  // The address is a plain {pass, col} concatenation, so COLS must tile the address space.
  if ((1 << COL_W) != COLS) begin : g_cols_not_pow2
    $error("result_unload_unit: COLS must be a power of two");
  end
  if ((ADDR_W <= COL_W) || ((1 << ADDR_W) != RESULT_DEPTH)) begin : g_bad_addr_w
    $error("result_unload_unit: ADDR_W inconsistent with COLS/RESULT_DEPTH");
  end

  unload_state_e     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              done_q, done_d;
  logic              load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      col_d   = '0;
      pass_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psum_valid) begin
            load    = 1'b1;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (res_ready) begin
            if (col_q == COL_W'(COLS - 1)) begin
              col_d   = '0;
              pass_d  = pass_q + PASS_W'(1);
              state_d = IDLE;
              done_d  = (pass_q == '1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer is only written in IDLE, so data stays stable while a word is stalled.
  result_capture_buffer u_capture_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .psum_in_i (psum_in),
    .rd_col_i  (col_q),
    .rd_data_o (res_data)
  );

  assign psum_ready  = (state_q == IDLE);
  assign res_valid   = (state_q == STREAM);
  assign res_addr    = {pass_q, col_q};
  assign unload_done = done_q;

endmodule

// File: doc/result_unload_unit.md
Name: result_unload_unit

Overview:
- Reader-side counterpart to the pre-load path: drains the systolic array's final column partial sums and streams them out as addressed result words.
- When a compute pass finishes, the 8 column sums are captured in parallel. They are then emitted one column per handshake as (address, data) pairs toward the result memory or host.
- Sits after the compensation-accumulator / final-partial-sum stage. Mirrors the 64-entry, 6-bit-address memory load sequence in the read direction.

Parameters:
- COLS, 8, number of array columns captured per pass
- PSUM_W, 16, signed width of one final partial sum
- ADDR_W, 6, result address width (64 entries)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear: abort stream, zero counters
- psum_valid  in  1  final partial sums available this cycle
- psum_ready  out  1  block can capture a new pass
- psum_in  in  COLS*PSUM_W  flattened column sums, column 0 in LSBs, signed
- res_valid  out  1  res_data/res_addr valid
- res_ready  in  1  downstream accepts result word
- res_data  out  PSUM_W  result word, signed
- res_addr  out  ADDR_W  result address = pass_cnt*COLS + col
- unload_done  out  1  one-cycle pulse when address 2^ADDR_W-1 is accepted

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; psum_ready=1; res_valid=0; res_data=0; res_addr=0; unload_done=0; col=0; pass_cnt=0; capture buffer zeroed.
- FSM states:
  - IDLE: psum_ready=1. On psum_valid&psum_ready, latch all COLS sums into the buffer and go to STREAM. res_valid rises the next cycle with column 0. Latency is 1 clock from capture to first word.
  - STREAM: psum_ready=0, res_valid=1. res_data=buffer[col]; res_addr={pass_cnt,col}.
    - On res_valid&res_ready: col increments; res_data/res_addr update the next cycle.
    - After col=COLS-1 is accepted: col=0, pass_cnt increments, return to IDLE. res_valid=0 and psum_ready=1 the following cycle.
    - Minimum 1 idle cycle between passes. Full-throughput stream is COLS words in COLS cycles.
- Handshake:
  - res_data/res_addr must stay stable while res_valid=1 and res_ready=0.
  - res_valid never drops without a handshake (except clr/reset).
  - psum_valid while psum_ready=0 is ignored. The source must hold it.
- Wrap-around:
  - pass_cnt is ADDR_W-log2(COLS) bits and wraps to 0 after the last pass.
  - unload_done pulses in the cycle after acceptance of address 63, concurrent with returning to IDLE.
- clr:
  - Synchronous; overrides everything.
  - Next state IDLE, col=0, pass_cnt=0, res_valid=0, unload_done=0. Buffer contents are don't-care.
- Simultaneous clr and handshake: clr wins and the word counts as not delivered.
- Reset mid-stream: immediate return to reset values; partially sent pass is lost.
- Arithmetic:
  - No width change. Data are passed through as two's-complement PSUM_W.
  - Address concatenation requires COLS to be a power of two. Elaboration error otherwise.

Optional Feature:
- Macro RESULT_UNLOAD_RELU_EN.
- Defined: at capture, each column sum with MSB=1 is stored as 0 (ReLU). Non-negative values are unchanged. Latency is unchanged.
- Undefined: raw signed sums are stored and emitted.

Decomposition:
- Shared package holds:
  - constants COLS, PSUM_W, ADDR_W, RESULT_DEPTH=64
  - FSM state typedef (IDLE, STREAM)
  - psum word typedef
- One natural sub-module: result_capture_buffer. It holds the COLS-entry register file with parallel load, column-indexed read mux and optional ReLU clamp.
- FSM, counters and handshake stay in the top.

Test Plan:
- Reset/idle: rst low mid-simulation → res_valid=0, psum_ready=1, res_addr=0; release, hold psum_valid=0 for 10 cycles → no outputs change.
- Single pass, res_ready tied 1:
  - Stimulus: psum_in columns = {100,-5,0,32767,-32768,1,2,3}.
  - Response: 8 consecutive words with addr 0..7, exact values in column order. First res_valid exactly 1 cycle after capture; psum_ready returns 1 after word 7.
- Backpressure: toggle res_ready randomly (about 50%) during a pass → no word dropped or duplicated; data/addr held stable while stalled; sequence identical to the no-stall run.
- Full depth + wrap:
  - Stimulus: 8 passes with column c of pass p = p*8+c.
  - Response: addresses 0..63 in order with matching data; unload_done pulses exactly once, after addr 63. The 9th pass restarts at addr 0.
- clr mid-stream: clr asserted after 3 words of pass 2 → res_valid=0 next cycle; next captured pass starts at addr 0, col 0.
- RELU_EN build: pass {-1,5,-200,0,...} → emitted {0,5,0,0,...}. Without the macro the same pass emits {-1,5,-200,0,...}.
